// File: rtl/serial_byte_rx_if.sv
// Output handshake of serial_byte_rx: a one-entry valid/ready word register.
// The receiver drives the word and its valid flag (master), the consumer
// drives ready (slave).
interface serial_byte_rx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/serial_byte_rx.sv
// Bit-serial frame receiver: low start bit, DATA_W data bits LSB-first,
// high stop bit, all sampled on bit_en strobes. The received word lands in a
// one-entry valid/ready output register. A stop bit sampled low raises
// frame_err. A word that arrives while the register still holds an unaccepted
// word raises overrun. Both flags are one-cycle pulses.
module serial_byte_rx #(
    parameter int DATA_W = 8
) (
    input  logic             C,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             din,
    serial_byte_rx_if.master out_if,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STOP  = 2'd2,
        BREAK = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shreg_q;
    logic              deliver;
    logic              stop_bad;
    logic              accept;

    // State register; bit_en gating lives in the next-state logic.
    always_ff @(posedge C or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: every sequential assignment is non-blocking so all
            // registers see the values from before this edge.
            state_q <= state_d;
        end
    end

    // Next-state: advance only on a sample strobe, otherwise hold.
    always_comb begin
        // NOTE: default first, so paths that assign nothing hold instead of
        // inferring a latch.
        state_d = state_q;
        if (bit_en) begin
            unique case (state_q)
                IDLE:  if (!din) state_d = DATA;
                DATA:  if (cnt_q == LAST_BIT) state_d = STOP;
                STOP:  state_d = din ? IDLE : BREAK;
                BREAK: if (din) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Decoded outputs and stop-bit events for the output register.
    always_comb begin
        busy     = (state_q != IDLE);
        deliver  = bit_en && (state_q == STOP) && din;
        stop_bad = bit_en && (state_q == STOP) && !din;
        accept   = out_if.dout_valid && out_if.dout_ready;
    end

    // Bit counter and shift register; both hold between strobes.
    always_ff @(posedge C or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else if (bit_en) begin
            if (state_q == IDLE && !din) begin
                cnt_q <= '0;
            end else if (state_q == DATA) begin
                shreg_q <= {din, shreg_q[DATA_W-1:1]};
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Output word register, handshake and one-cycle error pulses; runs every cycle.
    always_ff @(posedge C or negedge rst_n) begin
        if (!rst_n) begin
            out_if.dout       <= '0;
            out_if.dout_valid <= 1'b0;
            frame_err         <= 1'b0;
            overrun           <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= deliver && out_if.dout_valid && !out_if.dout_ready;
            if (deliver && (!out_if.dout_valid || out_if.dout_ready)) begin
                out_if.dout       <= shreg_q;
                out_if.dout_valid <= 1'b1;
            end else if (accept) begin
                out_if.dout_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed bench for serial_byte_rx. Stimulus pushes every word that should be
// handed to the consumer into a queue. A monitor pops and compares on each
// accept and also counts error pulses, checking that each lasts one cycle.
module tb_serial_byte_rx;
    logic C;
    logic rst_n;
    logic bit_en;
    logic din;
    logic frame_err;
    logic overrun;
    logic busy;

    serial_byte_rx_if #(.DATA_W(8)) rx_if ();

    serial_byte_rx #(.DATA_W(8)) dut (
        .C         (C),
        .rst_n     (rst_n),
        .bit_en    (bit_en),
        .din       (din),
        .out_if    (rx_if),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    // One frame: start, 8 data bits LSB-first, stop. Each bit is held for
    // `period` cycles with the strobe on the last of them.
    task automatic send_frame(input logic [7:0] w, input logic stop,
                              input int period, input logic ready_on_stop);
        logic [9:0] bits;
        bits = {stop, w, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < period; k++) begin
                din    = bits[i];
                bit_en = (k == period - 1);
                if (ready_on_stop && i == 9 && k == period - 1)
                    rx_if.dout_ready = 1'b1;
                tick();
            end
        end
        bit_en = 1'b0;
        din    = 1'b1;
    endtask

    // Monitor: accepts are compared against the scoreboard queue.
    initial begin
        logic prev_ferr;
        logic prev_ovr;
        logic [7:0] exp_w;
        prev_ferr = 1'b0;
        prev_ovr  = 1'b0;
        forever begin
            @(negedge C);
            if (rst_n) begin
                if (rx_if.dout_valid && rx_if.dout_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_word: actual=%0h required=none", rx_if.dout);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("sb_word", 32'(rx_if.dout), 32'(exp_w));
                    end
                end
                if (frame_err && !prev_ferr) ferr_cnt++;
                if (overrun && !prev_ovr) ovr_cnt++;
                if (frame_err && prev_ferr) check("frame_err_width", 32'd2, 32'd1);
                if (overrun && prev_ovr) check("overrun_width", 32'd2, 32'd1);
                prev_ferr = frame_err;
                prev_ovr  = overrun;
            end else begin
                prev_ferr = 1'b0;
                prev_ovr  = 1'b0;
            end
        end
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bit_en = 1'b0;
        din = 1'b1;
        rx_if.dout_ready = 1'b0;
        repeat (3) tick();
        check("rst_dout", 32'(rx_if.dout), 32'h0);
        check("rst_valid", 32'(rx_if.dout_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_flags", 32'({frame_err, overrun}), 32'h0);
        #2 rst_n = 1'b1;

        // Idle line with strobes: nothing may happen.
        bit_en = 1'b1;
        din = 1'b1;
        repeat (20) tick();
        bit_en = 1'b0;
        check("idle_valid", 32'(rx_if.dout_valid), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_dout", 32'(rx_if.dout), 32'h0);
        check("idle_flags", 32'(ferr_cnt + ovr_cnt), 32'h0);

        // Single frame 0xA5, visible the cycle after the stop sample.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1, 1'b0);
        check("a5_valid", 32'(rx_if.dout_valid), 32'h1);
        check("a5_dout", 32'(rx_if.dout), 32'hA5);
        check("a5_busy", 32'(busy), 32'h0);
        rx_if.dout_ready = 1'b1;
        tick();
        rx_if.dout_ready = 1'b0;
        check("a5_accepted", 32'(rx_if.dout_valid), 32'h0);
        check("a5_dout_hold", 32'(rx_if.dout), 32'hA5);

        // Framing error, stuck-low line, then a clean 0x81.
        send_frame(8'h3C, 1'b0, 1, 1'b0);
        din = 1'b0;
        bit_en = 1'b1;
        repeat (3) tick();
        bit_en = 1'b0;
        check("ferr_count", 32'(ferr_cnt), 32'd1);
        check("ferr_valid", 32'(rx_if.dout_valid), 32'h0);
        check("ferr_break_busy", 32'(busy), 32'h1);
        din = 1'b1;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        check("break_exit", 32'(busy), 32'h0);
        rx_if.dout_ready = 1'b1;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1, 1'b0);
        tick();
        rx_if.dout_ready = 1'b0;
        check("x81_drained", 32'(exp_q.size()), 32'd0);

        // Overrun: second word dropped while 0x11 is still held.
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1, 1'b0);
        send_frame(8'h22, 1'b1, 1, 1'b0);
        tick();
        check("ovr_count", 32'(ovr_cnt), 32'd1);
        check("ovr_dout", 32'(rx_if.dout), 32'h11);
        check("ovr_valid", 32'(rx_if.dout_valid), 32'h1);
        rx_if.dout_ready = 1'b1;
        tick();
        rx_if.dout_ready = 1'b0;

        // Accept on the same edge as the second stop sample: replace, no overrun.
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1, 1, 1'b0);
        send_frame(8'h22, 1'b1, 1, 1'b1);
        check("replace_dout", 32'(rx_if.dout), 32'h22);
        check("replace_valid", 32'(rx_if.dout_valid), 32'h1);
        tick();
        rx_if.dout_ready = 1'b0;
        tick();
        check("replace_no_ovr", 32'(ovr_cnt), 32'd1);
        check("replace_drained", 32'(exp_q.size()), 32'd0);

        // Strobe gating: a low line without strobes must not start a frame.
        din = 1'b0;
        bit_en = 1'b0;
        repeat (5) tick();
        check("gate_no_start", 32'(busy), 32'h0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 4, 1'b0);
        check("gate_dout", 32'(rx_if.dout), 32'h5A);
        check("gate_valid", 32'(rx_if.dout_valid), 32'h1);
        rx_if.dout_ready = 1'b1;
        tick();
        rx_if.dout_ready = 1'b0;

        // Async reset after the 4th data bit.
        bit_en = 1'b1;
        din = 1'b0;
        tick();
        din = 1'b1;
        repeat (4) tick();
        bit_en = 1'b0;
        check("mid_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dout", 32'(rx_if.dout), 32'h0);
        check("arst_valid", 32'(rx_if.dout_valid), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_flags", 32'({frame_err, overrun}), 32'h0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 1, 1'b0);
        check("ff_dout", 32'(rx_if.dout), 32'hFF);
        rx_if.dout_ready = 1'b1;
        tick();
        rx_if.dout_ready = 1'b0;
        tick();
        check("final_drained", 32'(exp_q.size()), 32'd0);
        check("final_ferr", 32'(ferr_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
